// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and imem.
// Single outstanding request: req/addr held until gnt, one rvalid per grant.
interface fetch_pc_ctrl_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues one imem request at a time and
// presents instructions to decode through a stallable output register plus one skid entry.
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   fetch_pc_ctrl_if.master        imem,
   output logic [31:0]            pc,
   output logic                   if_valid,
   output logic [31:0]            if_pc,
   output logic [31:0]            if_instr
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StHold,
      StDrop
   } state_t;

   state_t      state_q;
   logic [31:0] skid_pc_q;
   logic [31:0] skid_instr_q;
   logic        consume;

   assign consume = if_valid && !stall;

   // imem.addr keeps the address of the last request, so it doubles as the PC of the
   // response that comes back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         pc           <= RESET_PC;
         imem.req     <= 1'b0;
         imem.addr    <= '0;
         if_valid     <= 1'b0;
         if_pc        <= '0;
         if_instr     <= '0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else if (redirect && state_q != StIdle) begin
         pc           <= redirect_pc & ~32'd3;
         imem.req     <= 1'b0;
         if_valid     <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         // Leave through DROP only while a response is still owed by imem.
         if (state_q == StDrop) begin
            state_q <= imem.rvalid ? StReq : StDrop;
         end else if ((state_q == StWait && !imem.rvalid) ||
                      (state_q == StReq && imem.req && imem.gnt)) begin
            state_q <= StDrop;
         end else begin
            state_q <= StReq;
         end
      end else begin
         if (consume) begin
            if_valid <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               state_q <= StReq;
            end
            StReq: begin
               if (!imem.req) begin
                  imem.req  <= 1'b1;
                  imem.addr <= pc;
               end else if (imem.gnt) begin
                  imem.req <= 1'b0;
                  pc       <= pc + PC_STEP;
                  state_q  <= StWait;
               end
            end
            StWait: begin
               if (imem.rvalid) begin
                  if (!if_valid || consume) begin
                     if_valid <= 1'b1;
                     if_pc    <= imem.addr;
                     if_instr <= imem.rdata;
                     state_q  <= StReq;
                  end else begin
                     skid_pc_q    <= imem.addr;
                     skid_instr_q <= imem.rdata;
                     state_q      <= StHold;
                  end
               end
            end
            StHold: begin
               if (consume) begin
                  if_valid <= 1'b1;
                  if_pc    <= skid_pc_q;
                  if_instr <= skid_instr_q;
                  state_q  <= StReq;
               end
            end
            StDrop: begin
               if (imem.rvalid) begin
                  state_q <= StReq;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
